// File: rtl/mttkrp_pkg.sv
// Shared types for the MTTKRP datapath: row geometry and the per-channel fetch state.
package mttkrp_pkg;
   localparam int FACTOR_MATRIX_WIDTH = 32;
   localparam int RANK_FACTOR_MATRIX  = 16;

   typedef logic [RANK_FACTOR_MATRIX-1:0][FACTOR_MATRIX_WIDTH-1:0] row_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2
   } chan_state_t;
endpackage

// File: rtl/factor_row_bank.sv
// Single-port synchronous row RAM; a write in the same cycle suppresses the read.
module factor_row_bank
   import mttkrp_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  row_t                  wdata,
   output row_t                  rdata
);

   row_t mem [2**ADDR_WIDTH];
   row_t rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end else if (re) begin
         rdata_q <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/factor_row_server.sv
// Factor-matrix row server: one bank plus one request/hold channel per input mode,
// with a host load port, sticky error flags and an acknowledged-row counter.
module factor_row_server
   import mttkrp_pkg::*;
#(
   parameter  int TENSOR_DIMENSIONS      = 3,
   parameter  int MODE_TENSOR_ADDR_WIDTH = 16,
   parameter  int ROW_ADDR_WIDTH         = 10,
   localparam int NM                     = TENSOR_DIMENSIONS - 1,
   localparam int LMW                    = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NM-1:0]                             req_addr_en,
   input  logic [NM-1:0][MODE_TENSOR_ADDR_WIDTH-1:0] req_addr,
   input  logic                                      factor_data_ack,
   output logic [NM-1:0]                             row_en,
   output row_t [NM-1:0]                             row_data,
   input  logic                                      load_en,
   input  logic [LMW-1:0]                            load_mode,
   input  logic [ROW_ADDR_WIDTH-1:0]                 load_addr,
   input  row_t                                      load_row,
   output logic                                      busy,
   output logic                                      err_range,
   output logic                                      err_overflow,
   output logic [31:0]                               served_count
);

   logic [NM-1:0] active;
   logic [NM-1:0] ovf_hit;
   logic [NM-1:0] rng_hit;
   logic [NM-1:0] leave_hold;

   for (genvar gi = 0; gi < NM; gi++) begin : g_chan
      chan_state_t                       state_q, state_d;
      logic [MODE_TENSOR_ADDR_WIDTH-1:0] addr_q, addr_d;
      logic                              range_q, range_d;
      logic                              bank_we, bank_re;
      logic                              ovf, rng, leave;
      logic                              req_oob;
      row_t                              bank_rdata;

      // A host load to this bank takes the port; a pending read simply waits.
      assign bank_we = load_en && (load_mode == LMW'(gi));
      assign bank_re = (state_q == READ) && !bank_we;
      assign req_oob = (req_addr[gi] >> ROW_ADDR_WIDTH) != '0;

      factor_row_bank #(
         .ADDR_WIDTH(ROW_ADDR_WIDTH)
      ) u_bank (
         .clk  (clk),
         .we   (bank_we),
         .re   (bank_re),
         .addr (bank_we ? load_addr : addr_q[ROW_ADDR_WIDTH-1:0]),
         .wdata(load_row),
         .rdata(bank_rdata)
      );

      always_comb begin
         state_d = state_q;
         addr_d  = addr_q;
         range_d = range_q;
         ovf     = 1'b0;
         rng     = 1'b0;
         leave   = 1'b0;
         case (state_q)
            IDLE: begin
               if (req_addr_en[gi]) begin
                  state_d = READ;
                  addr_d  = req_addr[gi];
                  range_d = req_oob;
                  rng     = req_oob;
               end
            end
            READ: begin
               ovf = req_addr_en[gi];
               if (!bank_we) begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               if (factor_data_ack) begin
                  leave = 1'b1;
                  if (req_addr_en[gi]) begin
                     state_d = READ;
                     addr_d  = req_addr[gi];
                     range_d = req_oob;
                     rng     = req_oob;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  ovf = req_addr_en[gi];
               end
            end
            default: state_d = IDLE;
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            range_q <= 1'b0;
         end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            range_q <= range_d;
         end
      end

      // The RAM output register is not reset, so the row is gated by state.
      assign row_en[gi]     = (state_q == HOLD);
      assign row_data[gi]   = (state_q == HOLD && !range_q) ? bank_rdata : '0;
      assign active[gi]     = (state_q != IDLE);
      assign ovf_hit[gi]    = ovf;
      assign rng_hit[gi]    = rng;
      assign leave_hold[gi] = leave;
   end

   logic        err_range_q, err_range_d;
   logic        err_overflow_q, err_overflow_d;
   logic [31:0] served_q, served_d;

   always_comb begin
      err_range_d    = err_range_q | (|rng_hit);
      err_overflow_d = err_overflow_q | (|ovf_hit);
      served_d       = served_q + 32'($countones(leave_hold));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_range_q    <= 1'b0;
         err_overflow_q <= 1'b0;
         served_q       <= '0;
      end else begin
         err_range_q    <= err_range_d;
         err_overflow_q <= err_overflow_d;
         served_q       <= served_d;
      end
   end

   assign busy         = |active;
   assign err_range    = err_range_q;
   assign err_overflow = err_overflow_q;
   assign served_count = served_q;

endmodule

// File: tb/tb_factor_row_server.sv
// Directed bench for factor_row_server: fetch, hold, load collision, range error,
// ack-plus-request and mid-operation reset, with hand-computed expectations.
module tb_factor_row_server;
   import mttkrp_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         req_addr_en;
   logic [1:0][15:0]   req_addr;
   logic               factor_data_ack;
   logic [1:0]         row_en;
   row_t [1:0]         row_data;
   logic               load_en;
   logic [0:0]         load_mode;
   logic [9:0]         load_addr;
   row_t               load_row;
   logic               busy;
   logic               err_range;
   logic               err_overflow;
   logic [31:0]        served_count;

   int n_checks = 0;
   int n_fail   = 0;

   row_t row_a, row_b, row_c, row_d, row_e;

   always #5 clk = ~clk;

   factor_row_server dut (
      .clk            (clk),
      .rst            (rst),
      .req_addr_en    (req_addr_en),
      .req_addr       (req_addr),
      .factor_data_ack(factor_data_ack),
      .row_en         (row_en),
      .row_data       (row_data),
      .load_en        (load_en),
      .load_mode      (load_mode),
      .load_addr      (load_addr),
      .load_row       (load_row),
      .busy           (busy),
      .err_range      (err_range),
      .err_overflow   (err_overflow),
      .served_count   (served_count)
   );

   function automatic row_t mk_row(input int seed);
      row_t r;
      for (int i = 0; i < RANK_FACTOR_MATRIX; i++) begin
         r[i] = 32'(seed * 65536 + i * 257 + 1);
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int mode, input int addr, input row_t r);
      load_en   = 1'b1;
      load_mode = mode[0:0];
      load_addr = addr[9:0];
      load_row  = r;
      step();
      load_en   = 1'b0;
   endtask

   task automatic ack_once();
      factor_data_ack = 1'b1;
      step();
      factor_data_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++;
      if (row_en !== 2'b00) begin
         n_fail++; $display("FAIL reset_row_en: got %b expected 00", row_en);
      end
      n_checks++;
      if (row_data !== '0) begin
         n_fail++; $display("FAIL reset_row_data: got %h expected 0", row_data);
      end
      n_checks++;
      if ({busy, err_range, err_overflow} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, err_range, err_overflow});
      end
      n_checks++;
      if (served_count !== 32'd0) begin
         n_fail++; $display("FAIL reset_served: got %0d expected 0", served_count);
      end
      rst = 1'b0;
      step();
      ack_once();
      n_checks++;
      if (served_count !== 32'd0 || row_en !== 2'b00) begin
         n_fail++; $display("FAIL idle_ack: served %0d row_en %b expected 0 00", served_count, row_en);
      end
      $display("[tb] reset: outputs idle, stray ack ignored");
   endtask

   task automatic test_basic();
      load(0, 5, row_a);
      load(1, 9, row_b);
      load(0, 3, row_c);
      load(0, 7, row_e);
      req_addr_en = 2'b11;
      req_addr[0] = 16'd5;
      req_addr[1] = 16'd9;
      step();
      req_addr_en = 2'b00;
      n_checks++;
      if (row_en !== 2'b00 || busy !== 1'b1) begin
         n_fail++; $display("FAIL basic_t1: row_en %b busy %b expected 00 1", row_en, busy);
      end
      step();
      n_checks++;
      if (row_en !== 2'b11) begin
         n_fail++; $display("FAIL basic_row_en: got %b expected 11", row_en);
      end
      n_checks++;
      if (row_data[0] !== row_a || row_data[1] !== row_b) begin
         n_fail++; $display("FAIL basic_row_data: got %h / %h expected %h / %h",
                            row_data[0][0], row_data[1][0], row_a[0], row_b[0]);
      end
      ack_once();
      n_checks++;
      if (row_en !== 2'b00 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_release: row_en %b busy %b expected 00 0", row_en, busy);
      end
      n_checks++;
      if (served_count !== 32'd2) begin
         n_fail++; $display("FAIL basic_served: got %0d expected 2", served_count);
      end
      $display("[tb] basic: m0 addr 5, m1 addr 9, served=%0d", served_count);
   endtask

   task automatic test_collision();
      req_addr_en = 2'b01;
      req_addr[0] = 16'd3;
      step();
      req_addr_en = 2'b00;
      load_en   = 1'b1;
      load_mode = 1'b0;
      load_addr = 10'd3;
      load_row  = row_d;
      step();
      load_en = 1'b0;
      n_checks++;
      if (row_en !== 2'b00) begin
         n_fail++; $display("FAIL collision_t2: row_en %b expected 00", row_en);
      end
      step();
      n_checks++;
      if (row_en !== 2'b01) begin
         n_fail++; $display("FAIL collision_t3: row_en %b expected 01", row_en);
      end
      n_checks++;
      if (row_data[0] !== row_d) begin
         n_fail++; $display("FAIL collision_data: got %h expected %h", row_data[0][0], row_d[0]);
      end
      ack_once();
      n_checks++;
      if (served_count !== 32'd3) begin
         n_fail++; $display("FAIL collision_served: got %0d expected 3", served_count);
      end
      $display("[tb] collision: m0 addr 3 reloaded during read, served=%0d", served_count);
   endtask

   task automatic test_range();
      req_addr_en = 2'b10;
      req_addr[1] = 16'h0400;
      step();
      req_addr_en = 2'b00;
      step();
      n_checks++;
      if (row_en !== 2'b10) begin
         n_fail++; $display("FAIL range_row_en: got %b expected 10", row_en);
      end
      n_checks++;
      if (row_data[1] !== '0) begin
         n_fail++; $display("FAIL range_row_data: got %h expected 0", row_data[1]);
      end
      n_checks++;
      if (err_range !== 1'b1 || err_overflow !== 1'b0) begin
         n_fail++; $display("FAIL range_flags: range %b ovf %b expected 1 0", err_range, err_overflow);
      end
      ack_once();
      n_checks++;
      if (served_count !== 32'd4 || row_en !== 2'b00) begin
         n_fail++; $display("FAIL range_ack: served %0d row_en %b expected 4 00", served_count, row_en);
      end
      $display("[tb] range: m1 addr 0400, served=%0d", served_count);
   endtask

   task automatic test_ack_req();
      req_addr_en = 2'b01;
      req_addr[0] = 16'd5;
      step();
      req_addr_en = 2'b00;
      step();
      n_checks++;
      if (row_en !== 2'b01 || row_data[0] !== row_a) begin
         n_fail++; $display("FAIL ackreq_hold: row_en %b data %h expected 01 %h", row_en, row_data[0][0], row_a[0]);
      end
      factor_data_ack = 1'b1;
      req_addr_en     = 2'b01;
      req_addr[0]     = 16'd7;
      step();
      factor_data_ack = 1'b0;
      req_addr_en     = 2'b00;
      n_checks++;
      if (row_en !== 2'b00 || err_overflow !== 1'b0) begin
         n_fail++; $display("FAIL ackreq_gap: row_en %b ovf %b expected 00 0", row_en, err_overflow);
      end
      step();
      n_checks++;
      if (row_en !== 2'b01 || row_data[0] !== row_e) begin
         n_fail++; $display("FAIL ackreq_row7: row_en %b data %h expected 01 %h", row_en, row_data[0][0], row_e[0]);
      end
      n_checks++;
      if (err_overflow !== 1'b0 || served_count !== 32'd5) begin
         n_fail++; $display("FAIL ackreq_state: ovf %b served %0d expected 0 5", err_overflow, served_count);
      end
      ack_once();
      n_checks++;
      if (served_count !== 32'd6) begin
         n_fail++; $display("FAIL ackreq_served: got %0d expected 6", served_count);
      end
      $display("[tb] ack_req: m0 addr 5 then 7, served=%0d", served_count);
   endtask

   task automatic test_hold();
      req_addr_en = 2'b01;
      req_addr[0] = 16'd5;
      step();
      req_addr_en = 2'b00;
      step();
      for (int i = 0; i < 20; i++) begin
         n_checks++;
         if (row_en !== 2'b01 || row_data[0] !== row_a) begin
            n_fail++; $display("FAIL hold_stable[%0d]: row_en %b data %h expected 01 %h",
                               i, row_en, row_data[0][0], row_a[0]);
         end
         step();
      end
      req_addr_en = 2'b01;
      req_addr[0] = 16'd9;
      step();
      req_addr_en = 2'b00;
      n_checks++;
      if (err_overflow !== 1'b1) begin
         n_fail++; $display("FAIL hold_overflow: got %b expected 1", err_overflow);
      end
      n_checks++;
      if (row_en !== 2'b01 || row_data[0] !== row_a) begin
         n_fail++; $display("FAIL hold_after_drop: row_en %b data %h expected 01 %h", row_en, row_data[0][0], row_a[0]);
      end
      ack_once();
      n_checks++;
      if (served_count !== 32'd7 || err_overflow !== 1'b1) begin
         n_fail++; $display("FAIL hold_release: served %0d ovf %b expected 7 1", served_count, err_overflow);
      end
      $display("[tb] hold: m0 addr 5 held 20 cycles, dropped req, served=%0d", served_count);
   endtask

   task automatic test_rst_mid();
      req_addr_en = 2'b01;
      req_addr[0] = 16'd5;
      step();
      req_addr_en = 2'b00;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (row_en !== 2'b00 || busy !== 1'b0 || row_data !== '0) begin
         n_fail++; $display("FAIL rstmid_outputs: row_en %b busy %b expected 00 0", row_en, busy);
      end
      n_checks++;
      if (err_range !== 1'b0 || err_overflow !== 1'b0 || served_count !== 32'd0) begin
         n_fail++; $display("FAIL rstmid_counters: range %b ovf %b served %0d expected 0 0 0",
                            err_range, err_overflow, served_count);
      end
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (row_en !== 2'b00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_quiet[%0d]: row_en %b busy %b expected 00 0", i, row_en, busy);
         end
      end
      $display("[tb] rst_mid: reset during read, no row after release");
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst             = 1'b1;
      req_addr_en     = '0;
      req_addr        = '0;
      factor_data_ack = 1'b0;
      load_en         = 1'b0;
      load_mode       = '0;
      load_addr       = '0;
      load_row        = '0;
      row_a = mk_row(1);
      row_b = mk_row(2);
      row_c = mk_row(3);
      row_d = mk_row(4);
      row_e = mk_row(5);

      test_reset();
      test_basic();
      test_collision();
      test_range();
      test_ack_req();
      test_hold();
      test_rst_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
